// File: rtl/tunnel_painter.sv
// tunnel_painter: animated concentric-ring painter.
//
// Each pixel's exact Euclidean distance from (CX, CY) is computed with a fully
// pipelined restoring square root, then mapped together with the frame count to
// a 3-bit colour. One pixel is accepted per cycle. rgb belongs to the pixel that
// was presented LATENCY cycles earlier.
//
// Ports:
//   clk       system clock
//   reset     synchronous, active-high reset
//   frame     frame counter; travels with its pixel through the pipeline
//   subframe  PWM subframe, unused
//   x, y      pixel column / row
//   rgb       {red, green, blue}, forced to 0 until the pipeline holds valid data
//
// MODE 0: mono blue rings, MODE 1: 8-colour palette rings,
// MODE 2: independent R/G/B rings at 1x, 1/2x, 1/4x speed.
module tunnel_painter #(
  parameter int unsigned W           = 6,
  parameter int unsigned CX          = 32,
  parameter int unsigned CY          = 32,
  parameter int unsigned RING_SHIFT  = 0,
  parameter int unsigned SPEED_SHIFT = 2,
  parameter int unsigned MODE        = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic [9:0]   frame,
  input  logic [7:0]   subframe,
  input  logic [W-1:0] x,
  input  logic [W-1:0] y,
  output logic [2:0]   rgb
);

  localparam int unsigned LATENCY = W + 5;
  localparam int unsigned RADW    = 2 * W + 2;  // radicand padded to an even width
  localparam int unsigned RW      = W + 3;      // remainder width

  localparam logic [W-1:0] CxW = W'(CX);
  localparam logic [W-1:0] CyW = W'(CY);

  // ---------------------------------------------------------------------------
  // Stage 1: absolute offsets from the centre
  // ---------------------------------------------------------------------------
  logic [W-1:0] dx_d, dy_d, dx_q, dy_q;
  logic [9:0]   fr1_q;

  always_comb begin
    dx_d = (x >= CxW) ? (x - CxW) : (CxW - x);
    dy_d = (y >= CyW) ? (y - CyW) : (CyW - y);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dx_q  <= '0;
      dy_q  <= '0;
      fr1_q <= '0;
    end else begin
      dx_q  <= dx_d;
      dy_q  <= dy_d;
      fr1_q <= frame;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 2: squares
  // ---------------------------------------------------------------------------
  logic [2*W-1:0] dx2_d, dy2_d, dx2_q, dy2_q;
  logic [9:0]     fr2_q;

  always_comb begin
    dx2_d = {{W{1'b0}}, dx_q} * {{W{1'b0}}, dx_q};
    dy2_d = {{W{1'b0}}, dy_q} * {{W{1'b0}}, dy_q};
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      dx2_q <= '0;
      dy2_q <= '0;
      fr2_q <= '0;
    end else begin
      dx2_q <= dx2_d;
      dy2_q <= dy2_d;
      fr2_q <= fr1_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stage 3: squared distance; the extra bit makes overflow impossible
  // ---------------------------------------------------------------------------
  logic [2*W:0] r2_q;
  logic [9:0]   fr3_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      r2_q  <= '0;
      fr3_q <= '0;
    end else begin
      r2_q  <= {1'b0, dx2_q} + {1'b0, dy2_q};
      fr3_q <= fr2_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Stages 4 .. W+4: restoring square root, one root bit per stage, MSB first.
  // Each stage pulls the next two radicand bits into the remainder and tries
  // subtracting {root, 01}; success sets the new root bit.
  // ---------------------------------------------------------------------------
  for (genvar j = 0; j <= W; j++) begin : g_sqrt
    logic [RADW-1:0] rad_in, rad_q;
    logic [RW-1:0]   rem_in, rem_q;
    logic [W:0]      root_in, root_q;
    logic [9:0]      fr_in, fr_q;
    logic [RW+1:0]   rem_sh, trial;
    logic            ge;

    if (j == 0) begin : g_first
      assign rad_in  = {1'b0, r2_q};
      assign rem_in  = '0;
      assign root_in = '0;
      assign fr_in   = fr3_q;
    end else begin : g_rest
      assign rad_in  = g_sqrt[j-1].rad_q;
      assign rem_in  = g_sqrt[j-1].rem_q;
      assign root_in = g_sqrt[j-1].root_q;
      assign fr_in   = g_sqrt[j-1].fr_q;
    end

    always_comb begin
      rem_sh = {rem_in, rad_in[RADW-1 -: 2]};
      trial  = {2'b00, root_in, 2'b01};
      ge     = (rem_sh >= trial);
    end

    always_ff @(posedge clk) begin
      if (reset) begin
        rad_q  <= '0;
        rem_q  <= '0;
        root_q <= '0;
        fr_q   <= '0;
      end else begin
        rad_q  <= rad_in << 2;
        rem_q  <= ge ? RW'(rem_sh - trial) : RW'(rem_sh);
        root_q <= {root_in[W-1:0], ge};
        fr_q   <= fr_in;
      end
    end
  end

  // Integer distance floor(sqrt(r2)), exposed for observation.
  logic [W:0] r_dist;
  logic [9:0] fr_out;
  assign r_dist = g_sqrt[W].root_q;
  assign fr_out = g_sqrt[W].fr_q;

  // ---------------------------------------------------------------------------
  // Stage W+5: colour
  // ---------------------------------------------------------------------------
  logic [W:0] r_ring;
  logic [W:0] phase [3];
  logic [W:0] c     [3];
  logic [2:0] rgb_d, rgb_q;

  always_comb begin
    r_ring = r_dist >> RING_SHIFT;
    for (int k = 0; k < 3; k++) begin
      // Phase is reduced modulo 2^(W+1), so the frame wrap is a single ring step.
      phase[k] = (W+1)'({22'd0, fr_out} >> (SPEED_SHIFT + 32'(k)));
      c[k]     = r_ring - phase[k];
    end
    rgb_d = 3'b000;
    if (MODE == 0) begin
      rgb_d = {2'b00, c[0][1] & c[0][0]};
    end else if (MODE == 1) begin
      rgb_d = c[0][2:0];
    end else begin
      rgb_d = {&c[0][1:0], &c[1][1:0], &c[2][1:0]};
    end
  end

  // One valid bit per pipeline stage; the top bit qualifies rgb_q.
  logic [LATENCY-1:0] valid_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      rgb_q   <= 3'b000;
      valid_q <= '0;
    end else begin
      rgb_q   <= rgb_d;
      valid_q <= {valid_q[LATENCY-2:0], 1'b1};
    end
  end

  assign rgb = valid_q[LATENCY-1] ? rgb_q : 3'b000;

  // Sink for bits that are intentionally not consumed.
  logic unused_sink;
  assign unused_sink = ^{g_sqrt[W].rad_q, g_sqrt[W].rem_q, subframe, c[0], c[1], c[2]};

endmodule

// File: tb/tb_tunnel_painter.sv
// Scoreboard bench for tunnel_painter: four instances (MODE 0/1/2 at W=6 and an
// off-centre W=5 instance) share one stimulus stream. Stimulus pushes expected
// values tagged with the cycle they are due; a negedge monitor pops and compares.
module tb_tunnel_painter;

  logic       clk = 1'b0;
  logic       reset;
  logic [9:0] frame;
  logic [7:0] subframe;
  logic [5:0] x, y;
  logic [4:0] x3, y3;
  logic [2:0] rgb0, rgb1, rgb2, rgb3;

  always #5 clk = ~clk;

  tunnel_painter #(.W(6), .CX(32), .CY(32), .RING_SHIFT(0), .SPEED_SHIFT(2), .MODE(0)) u_dut0 (
    .clk(clk), .reset(reset), .frame(frame), .subframe(subframe), .x(x), .y(y), .rgb(rgb0)
  );
  tunnel_painter #(.W(6), .CX(32), .CY(32), .RING_SHIFT(1), .SPEED_SHIFT(2), .MODE(1)) u_dut1 (
    .clk(clk), .reset(reset), .frame(frame), .subframe(subframe), .x(x), .y(y), .rgb(rgb1)
  );
  tunnel_painter #(.W(6), .CX(32), .CY(32), .RING_SHIFT(0), .SPEED_SHIFT(2), .MODE(2)) u_dut2 (
    .clk(clk), .reset(reset), .frame(frame), .subframe(subframe), .x(x), .y(y), .rgb(rgb2)
  );
  tunnel_painter #(.W(5), .CX(0), .CY(31), .RING_SHIFT(0), .SPEED_SHIFT(2), .MODE(0)) u_dut3 (
    .clk(clk), .reset(reset), .frame(frame), .subframe(subframe), .x(x3), .y(y3), .rgb(rgb3)
  );

  // Sources: 0..3 = rgb of dut0..3, 4 = r of dut0, 5 = r of dut3.
  typedef struct {
    int    due;
    int    src;
    int    exp;
    string name;
  } exp_t;

  exp_t sb[$];
  int   cyc = 0;
  int   n_checks = 0;
  int   n_fail = 0;

  always @(posedge clk) cyc <= cyc + 1;

  function automatic int get_act(input int src);
    case (src)
      0:       return int'(rgb0);
      1:       return int'(rgb1);
      2:       return int'(rgb2);
      3:       return int'(rgb3);
      4:       return int'(u_dut0.r_dist);
      default: return int'(u_dut3.r_dist);
    endcase
  endfunction

  // Monitor
  always @(negedge clk) begin
    int i;
    int act;
    i = 0;
    while (i < sb.size()) begin
      if (sb[i].due == cyc) begin
        act = get_act(sb[i].src);
        n_checks++;
        if (act != sb[i].exp) begin
          n_fail++;
          $display("FAIL %s: src %0d cycle %0d got %0d expected %0d",
                   sb[i].name, sb[i].src, cyc, act, sb[i].exp);
        end
        sb.delete(i);
      end else if (sb[i].due < cyc) begin
        n_checks++;
        n_fail++;
        $display("FAIL %s: src %0d due cycle %0d never sampled (got none, expected %0d)",
                 sb[i].name, sb[i].src, sb[i].due, sb[i].exp);
        sb.delete(i);
      end else begin
        i++;
      end
    end
  end

  // Reference model
  function automatic int isqrt(input int n);
    int r;
    r = 0;
    while ((r + 1) * (r + 1) <= n) r++;
    return r;
  endfunction

  function automatic int colour(input int mode, input int w, input int rs, input int ss,
                                input int r, input int f);
    int m;
    int rp;
    int c[3];
    m  = (1 << (w + 1)) - 1;
    rp = r >> rs;
    for (int k = 0; k < 3; k++) c[k] = (rp - ((f >> (ss + k)) & m)) & m;
    if (mode == 0) return ((c[0] & 3) == 3) ? 1 : 0;
    if (mode == 1) return c[0] & 7;
    return (((c[0] & 3) == 3) ? 4 : 0) | (((c[1] & 3) == 3) ? 2 : 0) |
           (((c[2] & 3) == 3) ? 1 : 0);
  endfunction

  function automatic void push(input int due, input int src, input int exp, input string name);
    exp_t e;
    e.due  = due;
    e.src  = src;
    e.exp  = exp;
    e.name = name;
    sb.push_back(e);
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int xx, input int yy, input int f);
    x     = 6'(xx);
    y     = 6'(yy);
    x3    = 5'(xx);
    y3    = 5'(yy);
    frame = 10'(f);
  endtask

  // Pixel with model-derived expectations on every instance.
  task automatic px_model(input int xx, input int yy, input int f, input string name);
    int r0, r3, x5, y5;
    drive(xx, yy, f);
    x5 = xx & 31;
    y5 = yy & 31;
    r0 = isqrt((32 - xx) * (32 - xx) + (32 - yy) * (32 - yy));
    r3 = isqrt(x5 * x5 + (31 - y5) * (31 - y5));
    push(cyc + 10, 4, r0, name);
    push(cyc + 11, 0, colour(0, 6, 0, 2, r0, f), name);
    push(cyc + 11, 1, colour(1, 6, 1, 2, r0, f), name);
    push(cyc + 11, 2, colour(2, 6, 0, 2, r0, f), name);
    push(cyc + 9,  5, r3, name);
    push(cyc + 10, 3, colour(0, 5, 0, 2, r3, f), name);
    step();
  endtask

  // Pixel with hand-computed expectations; negative means not checked.
  task automatic px_hand(input int xx, input int yy, input int f, input int e0, input int e1,
                         input int e2, input int e3, input int er0, input int er3,
                         input string name);
    drive(xx, yy, f);
    if (e0 >= 0)  push(cyc + 11, 0, e0, name);
    if (e1 >= 0)  push(cyc + 11, 1, e1, name);
    if (e2 >= 0)  push(cyc + 11, 2, e2, name);
    if (e3 >= 0)  push(cyc + 10, 3, e3, name);
    if (er0 >= 0) push(cyc + 10, 4, er0, name);
    if (er3 >= 0) push(cyc + 9,  5, er3, name);
    step();
  endtask

  task automatic push_zeros(input int from, input int to6, input int to5, input string name);
    for (int d = from; d <= to6; d++) begin
      for (int s = 0; s < 3; s++) push(d, s, 0, name);
    end
    for (int d = from; d <= to5; d++) push(d, 3, 0, name);
  endtask

  initial begin
    int n;
    int m;
    reset    = 1'b1;
    subframe = 8'h5a;
    drive(0, 0, 0);

    // Reset held 3 cycles: outputs dark throughout.
    push_zeros(1, 3, 3, "in_reset");
    repeat (3) step();

    // Release; dark for LATENCY-1 more cycles, pixel 0 on cycle LATENCY.
    reset = 1'b0;
    n = cyc;
    push_zeros(n + 1, n + 10, n + 9, "post_reset_dark");

    px_hand(32, 36, 8, 0, 0, 2, -1, 4, -1, "mode0_f8");
    px_hand(32, 36, 4, 1, 1, 4, -1, 4, -1, "mode0_f4");
    px_hand(32, 46, 0, 0, 7, 0, -1, 14, -1, "mode1_r14");
    px_hand(32, 35, 0, 1, 1, 7, -1, 3, -1, "mode2_r3_f0");
    px_hand(32, 35, 4, 0, 0, 3, -1, 3, -1, "mode2_r3_f4");
    px_hand(0, 0, 0, 0, 6, 0, -1, 45, 31, "corner_0_0");
    px_hand(63, 63, 0, 1, 5, 7, -1, 43, 31, "corner_63_63");
    px_hand(32, 32, 0, 0, 0, 0, -1, 0, -1, "centre");
    px_hand(29, 28, 0, 0, 2, 0, -1, 5, -1, "pix_29_28");
    px_hand(31, 0, 0, 0, 0, 0, 1, 32, 43, "w5_offcentre");

    // Frame changes every cycle on a fixed pixel.
    px_hand(32, 36, 0,  0, 2, 0, -1, 4, -1, "tear_f0");
    px_hand(32, 36, 4,  1, 1, 4, -1, 4, -1, "tear_f4");
    px_hand(32, 36, 8,  0, 0, 2, -1, 4, -1, "tear_f8");
    px_hand(32, 36, 12, 0, 7, 2, -1, 4, -1, "tear_f12");
    px_hand(32, 36, 16, 0, 6, 1, -1, 4, -1, "tear_f16");

    // Frame wrap.
    px_model(32, 36, 1023, "wrap_1023");
    px_model(32, 36, 0, "wrap_0");
    px_model(5, 60, 1022, "wrap_1022");

    // Mid-stream reset: in-flight pixels must never appear.
    for (int i = 0; i < 5; i++) px_model(10 + i, 50 - i, 200 + i, "pre_kill");
    m = cyc;
    reset = 1'b1;
    for (int i = 0; i < sb.size(); i++) begin
      if (sb[i].due > m && sb[i].src < 4) begin
        sb[i].exp  = 0;
        sb[i].name = "killed";
      end
    end
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].due > m && sb[i].src >= 4) sb.delete(i);
    end
    push_zeros(m + 1, m + 2, m + 2, "kill_reset");
    step();
    step();
    reset = 1'b0;
    n = cyc;
    push_zeros(n + 1, n + 10, n + 9, "post_kill_dark");

    // Exhaustive sweep; frame varies per pixel.
    for (int yy = 0; yy < 64; yy++) begin
      for (int xx = 0; xx < 64; xx++) begin
        px_model(xx, yy, (yy * 64 + xx) & 1023, "sweep");
      end
    end

    repeat (14) step();
    while (sb.size() > 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL %s: src %0d due %0d left unchecked (got none, expected %0d)",
               sb[0].name, sb[0].src, sb[0].due, sb[0].exp);
      void'(sb.pop_front());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
